uart_loader: RTL and testbench

Program loader for ONC-16 that sits directly downstream of `uart_rx`. It consumes received bytes, parses a framed download (sync byte, word count, big-endian 16-bit words, checksum) and writes the words sequentially into instruction memory from address 0. It reports `done` only after the checksum verifies. `cpu_run` gates CPU start so the core stays held until a clean image has loaded.

---
 rtl/onc16_pkg.sv | 8 +
 rtl/timeout_counter.sv | 17 +
 rtl/uart_loader.sv | 104 ++++++++++
 tb/tb_uart_loader.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/onc16_pkg.sv
// onc16_pkg: shared ONC-16 types and constants for the program loader.
package onc16_pkg;
  localparam int WORD_W = 16;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERR
  } state_t;
endpackage

// File: rtl/timeout_counter.sv
// timeout_counter: counts idle clocks while enabled, flags the terminal count.
module timeout_counter #(
  parameter int TIMEOUT_CLKS = 2_170_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_reload,
  output logic o_expired
);
  localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (!i_en || i_reload) ? '0 : r_cnt + 1'b1;
  assign o_expired = i_en && !i_reload && (r_cnt == CW'(TIMEOUT_CLKS - 1));
endmodule

// File: rtl/uart_loader.sv
// uart_loader: parses a framed UART download and writes 16-bit words to instruction memory.
module uart_loader
  import onc16_pkg::*;
#(
  parameter int         ADDR_W       = 12,
  parameter int         TIMEOUT_CLKS = 2_170_000,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic              clock_50M,
  input  logic              n_rst,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              loading,
  output logic              done,
  output logic              error,
  output logic              cpu_run
);
  state_t r_state, w_next;
  logic r_rx_q, r_we;
  logic [15:0] r_len;
  logic [7:0] r_hi, r_sum;
  logic [ADDR_W:0] r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic w_acc, w_sync, w_last, w_too_long, w_timeout;
  logic [15:0] w_len_n;
  // rising edge of ready, so level-held and pulsed ready both give one byte
  assign w_acc      = rx_ready && !r_rx_q;
  assign w_sync     = rx_data == SYNC_BYTE;
  assign w_len_n    = {r_len[15:8], rx_data};
  assign w_too_long = 32'(w_len_n) > (32'd1 << ADDR_W);
  assign w_last     = 32'(r_cnt) + 32'd1 == 32'(r_len);
  assign loading    = r_state != S_IDLE && r_state != S_DONE && r_state != S_ERR;
  assign done       = r_state == S_DONE;
  assign error      = r_state == S_ERR;
  assign cpu_run    = done;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  timeout_counter #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
    .clk(clock_50M), .rst_n(n_rst), .i_en(loading), .i_reload(w_acc), .o_expired(w_timeout)
  );
  always_ff @(posedge clock_50M or negedge n_rst)
    if (!n_rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_timeout) w_next = S_ERR;
    else if (w_acc)
      case (r_state)
        S_LEN_HI:  w_next = S_LEN_LO;
        S_LEN_LO:  w_next = (w_len_n == 16'd0) ? S_CHECK : w_too_long ? S_ERR : S_DATA_HI;
        S_DATA_HI: w_next = S_DATA_LO;
        S_DATA_LO: w_next = w_last ? S_CHECK : S_DATA_HI;
        S_CHECK:   w_next = (rx_data == r_sum) ? S_DONE : S_ERR;
        default:   w_next = w_sync ? S_LEN_HI : r_state;
      endcase
  end
  always_ff @(posedge clock_50M or negedge n_rst)
    if (!n_rst) begin
      r_rx_q  <= 1'b0;
      r_we    <= 1'b0;
      r_len   <= '0;
      r_hi    <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_rx_q <= rx_ready;
      r_we   <= 1'b0;
      if (w_acc)
        case (r_state)
          S_LEN_HI: begin
            r_len[15:8] <= rx_data;
            r_sum       <= r_sum + rx_data;
          end
          S_LEN_LO: begin
            r_len[7:0] <= rx_data;
            r_sum      <= r_sum + rx_data;
          end
          S_DATA_HI: begin
            r_hi  <= rx_data;
            r_sum <= r_sum + rx_data;
          end
          S_DATA_LO: begin
            r_we    <= 1'b1;
            r_addr  <= r_cnt[ADDR_W-1:0];
            r_wdata <= {r_hi, rx_data};
            r_cnt   <= r_cnt + 1'b1;
            r_sum   <= r_sum + rx_data;
          end
          S_CHECK: ;
          default:
            if (w_sync) begin
              r_cnt <= '0;
              r_sum <= '0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: frame-level checks of uart_loader against a byte-stream reference model.
module tb_uart_loader;
  localparam int AW = 4;
  localparam int TO = 40;
  logic clk = 1'b0, n_rst = 1'b0, rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic mem_we, loading, done, error, cpu_run;
  logic [AW-1:0] mem_addr;
  logic [15:0] mem_wdata;
  int checks = 0, errors = 0;
  logic [7:0] tx_q[$];
  logic [19:0] exp_w[$], obs_w[$];
  typedef struct {int n; bit bad; bit exp_done; bit exp_err;} vec_t;
  vec_t vecs[8];
  always #5 clk = ~clk;
  uart_loader #(.ADDR_W(AW), .TIMEOUT_CLKS(TO)) dut (
    .clock_50M(clk), .n_rst(n_rst), .rx_ready(rx_ready), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .loading(loading), .done(done), .error(error), .cpu_run(cpu_run)
  );
  always @(negedge clk) if (mem_we) obs_w.push_back({mem_addr, mem_wdata});
  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic send_byte(logic [7:0] b);
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = b;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(0, 4)) @(negedge clk);
  endtask
  // reference: frame = sync, N big-endian, N words, sum of all non-sync bytes mod 256
  task automatic build(int n, bit bad);
    logic [7:0] s;
    logic [15:0] w;
    tx_q.delete();
    exp_w.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back(n[15:8]);
    tx_q.push_back(n[7:0]);
    s = n[15:8] + n[7:0];
    if (n <= (1 << AW)) begin
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
        exp_w.push_back({4'(i), w});
        s = s + w[15:8] + w[7:0];
      end
      tx_q.push_back(bad ? s + 8'd1 : s);
    end
  endtask
  task automatic spec_frame(logic [7:0] sum);
    tx_q.delete();
    exp_w.delete();
    tx_q = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, sum};
    exp_w.push_back({4'd0, 16'h1234});
    exp_w.push_back({4'd1, 16'hABCD});
  endtask
  task automatic run_frame(string tag);
    obs_w.delete();
    foreach (tx_q[i]) begin
      send_byte(tx_q[i]);
      if (i == 0 && tx_q[0] == 8'hA5) chk({tag, "_loading_mid"}, loading, 1);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic check_end(string tag, bit ed, bit ee);
    chk({tag, "_done"}, done, ed);
    chk({tag, "_error"}, error, ee);
    chk({tag, "_cpu_run"}, cpu_run, ed);
    chk({tag, "_loading"}, loading, 0);
    chk({tag, "_nwrites"}, obs_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), obs_w[i], exp_w[i]);
  endtask
  task automatic check_reset_outs(string tag);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_loading"}, loading, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_cpu_run"}, cpu_run, 0);
  endtask
  initial begin
    vecs[0] = '{1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{2, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{17, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{300, 1'b0, 1'b0, 1'b1};
    repeat (2) @(negedge clk);
    check_reset_outs("rst");
    n_rst = 1'b1;
    spec_frame(8'hC0);
    run_frame("spec_ok");
    check_end("spec_ok", 1, 0);
    spec_frame(8'hC1);
    run_frame("spec_bad");
    check_end("spec_bad", 0, 1);
    foreach (vecs[k]) begin
      build(vecs[k].n, vecs[k].bad);
      run_frame($sformatf("vec%0d", k));
      check_end($sformatf("vec%0d", k), vecs[k].exp_done, vecs[k].exp_err);
    end
    for (int k = 0; k < 8; k++) begin
      bit bad;
      bad = 1'($urandom);
      build($urandom_range(1, 16), bad);
      run_frame($sformatf("rnd%0d", k));
      check_end($sformatf("rnd%0d", k), !bad, bad);
    end
    tx_q = {8'hA5, 8'h00, 8'h02, 8'h12};
    exp_w.delete();
    run_frame("to");
    chk("to_pre_error", error, 0);
    chk("to_pre_loading", loading, 1);
    repeat (TO + 2) @(negedge clk);
    check_end("to", 0, 1);
    tx_q = {8'h55};
    run_frame("junk");
    check_end("junk", 0, 1);
    build(3, 0);
    run_frame("after_to");
    check_end("after_to", 1, 0);
    tx_q = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
    run_frame("mid");
    chk("mid_nwrites", obs_w.size(), 1);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_reset_outs("mid_rst");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    chk("mid_no_write_after_rst", obs_w.size(), 1);
    spec_frame(8'hC0);
    run_frame("reload");
    check_end("reload", 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
